// File: rtl/count_seq_monitor_if.sv
// count_seq_monitor_if: groups the sampled counter inputs and the monitor's status outputs.
//   en       upstream counter enable (compare only when high)
//   num      upstream 3-bit count value
//   clr      synchronous clear / re-arm request
//   locked   high while tracking a correct count sequence
//   match    one-cycle pulse, locked and num == MATCH_VAL
//   wrap     one-cycle pulse on a locked 7->0 step
//   wrap_cnt saturating count of wrap pulses
//   err      sticky sequence-error flag
//   err_cnt  saturating count of fault entries
// master drives the counter side; slave is the monitor.
interface count_seq_monitor_if;
   logic       en;
   logic [2:0] num;
   logic       clr;
   logic       locked;
   logic       match;
   logic       wrap;
   logic [7:0] wrap_cnt;
   logic       err;
   logic [3:0] err_cnt;

   modport master (
      output en, num, clr,
      input  locked, match, wrap, wrap_cnt, err, err_cnt
   );

   modport slave (
      input  en, num, clr,
      output locked, match, wrap, wrap_cnt, err, err_cnt
   );
endinterface

// File: rtl/count_seq_monitor.sv
// count_seq_monitor: watches an upstream 3-bit counter, locks after LOCK_CNT consecutive
// correct +1 steps, then flags match/wrap events and latches a sticky error on the first
// broken step while locked. All outputs are registered (one-cycle latency).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    count_seq_monitor_if.slave (en/num/clr in; locked/match/wrap/wrap_cnt/err/err_cnt out)
module count_seq_monitor #(
   parameter int unsigned LOCK_CNT  = 3,
   parameter logic [2:0]  MATCH_VAL = 3'd5
) (
   input logic                clk,
   input logic                reset,
   count_seq_monitor_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StSync, StTrack, StFault} state_e;

   // LOCK_CNT is limited to 1..7, so it fits the 3-bit good counter.
   localparam logic [2:0] LockVal = 3'(LOCK_CNT);

   state_e     state_q;
   logic [2:0] prev_q;
   logic [2:0] good_q;
   logic       locked_q;
   logic       match_q;
   logic       wrap_q;
   logic [7:0] wrap_cnt_q;
   logic       err_q;
   logic [3:0] err_cnt_q;

   logic [2:0] prev_inc;
   logic       step_ok;

   assign prev_inc = prev_q + 3'd1;
   assign step_ok  = (bus.num == prev_inc);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         prev_q     <= 3'd0;
         good_q     <= 3'd0;
         locked_q   <= 1'b0;
         match_q    <= 1'b0;
         wrap_q     <= 1'b0;
         wrap_cnt_q <= 8'd0;
         err_q      <= 1'b0;
         err_cnt_q  <= 4'd0;
      end else begin
         // prev always follows num, even when disabled, cleared or faulted.
         prev_q  <= bus.num;
         match_q <= 1'b0;
         wrap_q  <= 1'b0;
         if (bus.clr) begin
            // err_cnt deliberately survives a clear.
            state_q    <= StIdle;
            good_q     <= 3'd0;
            locked_q   <= 1'b0;
            wrap_cnt_q <= 8'd0;
            err_q      <= 1'b0;
         end else begin
            case (state_q)
               StIdle: begin
                  if (bus.en) begin
                     state_q <= StSync;
                     good_q  <= 3'd0;
                  end
               end
               StSync: begin
                  if (bus.en) begin
                     if (step_ok) begin
                        good_q <= good_q + 3'd1;
                        if (good_q + 3'd1 == LockVal) begin
                           state_q  <= StTrack;
                           locked_q <= 1'b1;
                        end
                     end else begin
                        good_q <= 3'd0;
                     end
                  end
               end
               StTrack: begin
                  if (bus.en) begin
                     if (step_ok) begin
                        match_q <= (bus.num == MATCH_VAL);
                        if (prev_q == 3'd7 && bus.num == 3'd0) begin
                           wrap_q <= 1'b1;
                           if (wrap_cnt_q != 8'hFF) wrap_cnt_q <= wrap_cnt_q + 8'd1;
                        end
                     end else begin
                        state_q  <= StFault;
                        locked_q <= 1'b0;
                        err_q    <= 1'b1;
                        if (err_cnt_q != 4'hF) err_cnt_q <= err_cnt_q + 4'd1;
                     end
                  end
               end
               StFault: begin
                  // Parked until clr.
                  locked_q <= 1'b0;
                  err_q    <= 1'b1;
               end
               default: begin
                  state_q  <= StIdle;
                  locked_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.locked   = locked_q;
   assign bus.match    = match_q;
   assign bus.wrap     = wrap_q;
   assign bus.wrap_cnt = wrap_cnt_q;
   assign bus.err      = err_q;
   assign bus.err_cnt  = err_cnt_q;

endmodule
